// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and helpers for the systolic matmul engine
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic        clamped;
    logic [63:0] value;
  } sat_t;

  function automatic int run_cycles(input int n);
    return 3 * n - 2;
  endfunction

  // Clamp a sign-extended accumulator to an ow-bit signed or unsigned range.
  function automatic sat_t saturate(input longint acc, input logic sgn, input int ow);
    longint hi;
    longint lo;
    sat_t   r;
    if (sgn) begin
      hi = (longint'(1) <<< (ow - 1)) - 1;
      lo = -(longint'(1) <<< (ow - 1));
    end else begin
      hi = (longint'(1) <<< ow) - 1;
      lo = 0;
    end
    r.clamped = (acc > hi) || (acc < lo);
    r.value   = (acc > hi) ? hi : ((acc < lo) ? lo : acc);
    return r;
  endfunction

endpackage

// File: rtl/mac_pe.sv
// rtl/mac_pe.sv - one output-stationary PE: multiply-accumulate with east/south operand forwarding
module mac_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic                  i_signed,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic [ACC_WIDTH-1:0]  o_acc
);

  localparam int PW = 2 * DATA_WIDTH + 2;

  logic signed [PW-1:0]   w_a_ext;
  logic signed [PW-1:0]   w_b_ext;
  logic signed [PW-1:0]   w_prod;
  logic [ACC_WIDTH-1:0]   w_prod_ext;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [DATA_WIDTH-1:0]  r_a;
  logic [DATA_WIDTH-1:0]  r_b;

  // Unsigned operands get a zero top bit, so one signed multiplier covers both modes.
  assign w_a_ext    = {{(DATA_WIDTH + 2){i_signed & i_a[DATA_WIDTH-1]}}, i_a};
  assign w_b_ext    = {{(DATA_WIDTH + 2){i_signed & i_b[DATA_WIDTH-1]}}, i_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{(ACC_WIDTH - PW){w_prod[PW-1]}}, w_prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else begin
      if (i_clr) begin
        r_acc <= '0;
      end else if (i_en) begin
        r_acc <= r_acc + w_prod_ext;
      end
      if (i_en) begin
        r_a <= i_a;
        r_b <= i_b;
      end
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/systolic_matmul_engine.sv
// rtl/systolic_matmul_engine.sv - NxN output-stationary systolic C = A x B (or C += A x B)
// with valid/ready handshakes, skewed feeders and saturating result registers.
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int N            = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   a [0:N-1][0:N-1],
  input  logic [DATA_WIDTH-1:0]   b [0:N-1][0:N-1],
  input  logic                    signed_mode,
  input  logic                    accumulate,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] c [0:N-1][0:N-1],
  output logic                    overflow,
  output logic                    busy
);

  // Counter runs one drain cycle past the last feed so the final MACs land before capture.
  localparam int RUN_CYCLES = run_cycles(N);
  localparam int CW         = $clog2(3 * N);

  state_t                  r_state;
  state_t                  w_next;
  logic [CW-1:0]           r_cnt;
  logic [DATA_WIDTH-1:0]   r_a [0:N-1][0:N-1];
  logic [DATA_WIDTH-1:0]   r_b [0:N-1][0:N-1];
  logic                    r_signed;

  logic                    w_accept;
  logic                    w_clr;
  logic                    w_en;
  logic                    w_last;
  logic [DATA_WIDTH-1:0]   w_a_feed [0:N-1];
  logic [DATA_WIDTH-1:0]   w_b_feed [0:N-1];
  logic [DATA_WIDTH-1:0]   w_a_h    [0:N-1][0:N];
  logic [DATA_WIDTH-1:0]   w_b_v    [0:N][0:N-1];
  logic [ACC_WIDTH-1:0]    w_acc    [0:N-1][0:N-1];
  logic [OUTPUT_WIDTH-1:0] w_c_sat  [0:N-1][0:N-1];
  logic [N*N-1:0]          w_clamp;

  assign w_accept = in_valid && in_ready;
  assign w_clr    = w_accept && !accumulate;
  assign w_en     = (r_state == RUN);
  assign w_last   = w_en && (r_cnt == CW'(RUN_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= '0;
        end
      end
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a      <= a;
        r_b      <= b;
        r_signed <= signed_mode;
        r_cnt    <= '0;
      end else if (w_en) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Row i carries a[i][t-i], column j carries b[t-j][j]; zero outside the matrix.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_a_feed[i] = '0;
      w_b_feed[i] = '0;
      for (int k = 0; k < N; k++) begin
        if (int'(r_cnt) == i + k) begin
          w_a_feed[i] = r_a[i][k];
          w_b_feed[i] = r_b[k][i];
        end
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_bfeed
    assign w_b_v[0][j] = w_b_feed[j];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    assign w_a_h[i][0] = w_a_feed[i];
    for (genvar j = 0; j < N; j++) begin : g_col
      sat_t                      w_sat;
      logic [OUTPUT_WIDTH-1:0]   w_val;
      logic [63-OUTPUT_WIDTH:0]  w_val_unused;

      mac_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_en),
        .i_clr   (w_clr),
        .i_signed(r_signed),
        .i_a     (w_a_h[i][j]),
        .i_b     (w_b_v[i][j]),
        .o_a     (w_a_h[i][j+1]),
        .o_b     (w_b_v[i+1][j]),
        .o_acc   (w_acc[i][j])
      );

      assign w_sat                 = saturate(longint'($signed(w_acc[i][j])), r_signed, OUTPUT_WIDTH);
      assign {w_val_unused, w_val} = w_sat.value;
      assign w_c_sat[i][j]         = w_val;
      assign w_clamp[i*N+j]        = w_sat.clamped;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          c[i][j] <= '0;
        end
      end
    end else if (w_last) begin
      c        <= w_c_sat;
      overflow <= |w_clamp;
    end
  end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// tb/tb_systolic_matmul_engine.sv - directed self-checking bench for systolic_matmul_engine (N=3)
module tb_systolic_matmul_engine;

  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int AW    = 24;
  localparam int OW    = 16;
  localparam int CHK_W = N * N * OW;

  localparam logic [CHK_W-1:0] EXP_SEQ = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
  localparam logic [CHK_W-1:0] EXP_DBL = {16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12, 16'd14, 16'd16, 16'd18};
  localparam logic [CHK_W-1:0] EXP_ROW = {16'd6, 16'd6, 16'd6, 16'd15, 16'd15, 16'd15, 16'd24, 16'd24, 16'd24};

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic          in_valid    = 1'b0;
  logic          in_ready;
  logic          signed_mode = 1'b0;
  logic          accumulate  = 1'b0;
  logic          out_valid;
  logic          out_ready   = 1'b0;
  logic          overflow;
  logic          busy;
  logic [DW-1:0] a [0:N-1][0:N-1];
  logic [DW-1:0] b [0:N-1][0:N-1];
  logic [OW-1:0] c [0:N-1][0:N-1];

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  always #5 clk = ~clk;

  systolic_matmul_engine #(
    .N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUTPUT_WIDTH(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .accumulate(accumulate),
    .out_valid(out_valid), .out_ready(out_ready), .c(c),
    .overflow(overflow), .busy(busy)
  );

  task automatic check(input string tag, input logic [CHK_W-1:0] got, input logic [CHK_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CHK_W-1:0] c_flat();
    logic [CHK_W-1:0] r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r = {r[CHK_W-OW-1:0], c[i][j]};
    return r;
  endfunction

  function automatic logic [CHK_W-1:0] splat(input logic [OW-1:0] v);
    logic [CHK_W-1:0] r = '0;
    for (int k = 0; k < N * N; k++) r = {r[CHK_W-OW-1:0], v};
    return r;
  endfunction

  task automatic fill(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a[i][j] = av;
        b[i][j] = bv;
      end
  endtask

  task automatic load_seq(input logic ones);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a[i][j] = DW'(i * N + j + 1);
        b[i][j] = (ones || i == j) ? 8'd1 : 8'd0;
      end
  endtask

  task automatic start_op(input logic sm, input logic acc);
    @(negedge clk);
    signed_mode = sm;
    accumulate  = acc;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hs_in_ready", CHK_W'(in_ready), CHK_W'(1));
    check("hs_busy", CHK_W'(busy), CHK_W'(0));
  endtask

  initial begin
    fill(8'd0, 8'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", CHK_W'(in_ready), CHK_W'(1));
    check("rst_out_valid", CHK_W'(out_valid), CHK_W'(0));
    check("rst_busy", CHK_W'(busy), CHK_W'(0));
    check("rst_overflow", CHK_W'(overflow), CHK_W'(0));
    check("rst_c", c_flat(), '0);

    load_seq(1'b0);
    start_op(1'b0, 1'b0);
    check("t1_busy", CHK_W'(busy), CHK_W'(1));
    check("t1_in_ready", CHK_W'(in_ready), CHK_W'(0));
    wait_done(lat);
    check("t1_latency", CHK_W'(lat), CHK_W'(8));
    check("t1_c", c_flat(), EXP_SEQ);
    check("t1_ovf", CHK_W'(overflow), CHK_W'(0));
    finish_op();

    fill(8'hFF, 8'h02);
    start_op(1'b1, 1'b0);
    wait_done(lat);
    check("t2s_c", c_flat(), splat(16'hFFFA));
    check("t2s_ovf", CHK_W'(overflow), CHK_W'(0));
    finish_op();
    start_op(1'b0, 1'b0);
    wait_done(lat);
    check("t2u_c", c_flat(), splat(16'h05FA));
    check("t2u_ovf", CHK_W'(overflow), CHK_W'(0));
    finish_op();

    fill(8'hFF, 8'hFF);
    start_op(1'b0, 1'b0);
    wait_done(lat);
    check("t3u_c", c_flat(), splat(16'hFFFF));
    check("t3u_ovf", CHK_W'(overflow), CHK_W'(1));
    finish_op();
    fill(8'h80, 8'h80);
    start_op(1'b1, 1'b0);
    wait_done(lat);
    check("t3s_c", c_flat(), splat(16'h7FFF));
    check("t3s_ovf", CHK_W'(overflow), CHK_W'(1));
    finish_op();

    fill(8'hFF, 8'h02);
    start_op(1'b1, 1'b0);
    wait_done(lat);
    finish_op();
    fill(8'h00, 8'h02);
    start_op(1'b0, 1'b1);
    wait_done(lat);
    check("mix_neg_c", c_flat(), '0);
    check("mix_neg_ovf", CHK_W'(overflow), CHK_W'(1));
    finish_op();

    load_seq(1'b0);
    start_op(1'b0, 1'b0);
    wait_done(lat);
    check("t4_op1", c_flat(), EXP_SEQ);
    finish_op();
    start_op(1'b0, 1'b1);
    wait_done(lat);
    check("t4_op2", c_flat(), EXP_DBL);
    finish_op();
    start_op(1'b0, 1'b0);
    wait_done(lat);
    check("t4_op3", c_flat(), EXP_SEQ);

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a[0][0]  = a[0][0] + 8'd1;
      @(posedge clk);
      #1;
      check("t5_c", c_flat(), EXP_SEQ);
      check("t5_out_valid", CHK_W'(out_valid), CHK_W'(1));
      check("t5_in_ready", CHK_W'(in_ready), CHK_W'(0));
      check("t5_ovf", CHK_W'(overflow), CHK_W'(0));
    end
    @(negedge clk);
    in_valid = 1'b0;
    a[0][0]  = 8'd1;
    finish_op();
    check("t5_c_kept", c_flat(), EXP_SEQ);
    check("t5_out_valid_low", CHK_W'(out_valid), CHK_W'(0));

    load_seq(1'b1);
    start_op(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", CHK_W'(out_valid), CHK_W'(0));
    check("t6_c", c_flat(), '0);
    check("t6_in_ready", CHK_W'(in_ready), CHK_W'(1));
    check("t6_busy", CHK_W'(busy), CHK_W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    start_op(1'b0, 1'b0);
    wait_done(lat);
    check("t6_latency", CHK_W'(lat), CHK_W'(8));
    check("t6_c_after", c_flat(), EXP_ROW);
    check("t6_ovf", CHK_W'(overflow), CHK_W'(0));
    finish_op();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
